// File: rtl/core_mem_responder.sv
//
// core_mem_responder
//
// Memory-side responder for the three-stage RISC-V core. It takes the core's
// instruction-fetch (icache_*) and load/store (dcache_*) requests and turns
// each one into a single word transaction on a valid/ready backing-memory
// interface. While the backing memory is busy, stall freezes the core. The
// returned data is registered and held on icache_dout / dcache_dout.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   icache_addr/re    : fetch byte address and request
//   icache_dout       : fetched word, changes only on a fetch response
//   dcache_addr/re/we : load/store byte address, load request, store byte enables
//   dcache_din        : lane-aligned store data
//   dcache_dout       : loaded word, changes only on a load response
//   stall             : high whenever the FSM is not in IDLE
//   mem_req_*         : backing request (valid/ready, word address, rw, data, mask)
//   mem_resp_*        : backing response / write acknowledge and read data
//
// Optional feature
//   MEM_RESP_IBUF_EN : when defined, adds a one-entry fetch buffer so that a
//                      repeated fetch of the same word completes without a stall.
//
module core_mem_responder #(
    parameter int MEM_ADDR_BITS = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              icache_addr,
    input  logic                     icache_re,
    output logic [31:0]              icache_dout,
    input  logic [31:0]              dcache_addr,
    input  logic                     dcache_re,
    input  logic [3:0]               dcache_we,
    input  logic [31:0]              dcache_din,
    output logic [31:0]              dcache_dout,
    output logic                     stall,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_req_rw,
    output logic [31:0]              mem_req_data,
    output logic [3:0]               mem_req_mask,
    input  logic                     mem_resp_valid,
    input  logic [31:0]              mem_resp_data
);

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [MEM_ADDR_BITS-1:0] i_addr_q, i_addr_d;
    logic [MEM_ADDR_BITS-1:0] d_addr_q, d_addr_d;
    logic [31:0]              d_din_q, d_din_d;
    logic [3:0]               d_we_q, d_we_d;
    logic                     d_re_q, d_re_d;
    logic                     i_pend_q, i_pend_d;
    logic [31:0]              icache_dout_q, icache_dout_d;
    logic [31:0]              dcache_dout_q, dcache_dout_d;

    logic [MEM_ADDR_BITS-1:0] i_word;
    logic [MEM_ADDR_BITS-1:0] d_word;
    logic                     data_req;
    logic                     d_is_store;
    logic                     d_is_load;
    logic                     fetch_hit;
    logic                     addr_bits_unused;

    // Byte offset bits are dropped; misaligned accesses are the core's concern.
    assign i_word           = icache_addr[MEM_ADDR_BITS+1:2];
    assign d_word           = dcache_addr[MEM_ADDR_BITS+1:2];
    assign addr_bits_unused = ^{icache_addr, dcache_addr};

    assign data_req   = dcache_re | (|dcache_we);
    // A store wins when the core raises both re and we for the same access.
    assign d_is_store = |d_we_q;
    assign d_is_load  = d_re_q & ~d_is_store;

`ifdef MEM_RESP_IBUF_EN
    logic                     ibuf_valid_q, ibuf_valid_d;
    logic [MEM_ADDR_BITS-1:0] ibuf_tag_q, ibuf_tag_d;
    logic [31:0]              ibuf_data_q, ibuf_data_d;
    logic                     i_hit_q, i_hit_d;
    logic                     store_hits_buf;

    // A store to the buffered word makes the buffered copy stale, so such a
    // fetch is never treated as a hit and is refetched after the store.
    assign store_hits_buf = (|dcache_we) && ibuf_valid_q && (d_word == ibuf_tag_q);
    assign fetch_hit      = icache_re && ibuf_valid_q && (i_word == ibuf_tag_q) && !store_hits_buf;
`else
    assign fetch_hit = 1'b0;
`endif

    // Next-state and output logic. In IDLE the request inputs are copied into
    // the latched registers every cycle; once busy only those copies are used,
    // so the core is free to wiggle its outputs while stalled. The data access
    // always goes first because it belongs to the older instruction.
    always_comb begin
        state_d       = state_q;
        i_addr_d      = i_addr_q;
        d_addr_d      = d_addr_q;
        d_din_d       = d_din_q;
        d_we_d        = d_we_q;
        d_re_d        = d_re_q;
        i_pend_d      = i_pend_q;
        icache_dout_d = icache_dout_q;
        dcache_dout_d = dcache_dout_q;
`ifdef MEM_RESP_IBUF_EN
        ibuf_valid_d  = ibuf_valid_q;
        ibuf_tag_d    = ibuf_tag_q;
        ibuf_data_d   = ibuf_data_q;
        i_hit_d       = i_hit_q;
`endif
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_rw    = 1'b0;
        mem_req_data  = '0;
        mem_req_mask  = '0;

        unique case (state_q)
            IDLE: begin
                i_addr_d = i_word;
                d_addr_d = d_word;
                d_din_d  = dcache_din;
                d_we_d   = dcache_we;
                d_re_d   = dcache_re;
                i_pend_d = icache_re && !fetch_hit;
`ifdef MEM_RESP_IBUF_EN
                i_hit_d = fetch_hit;
                if (store_hits_buf) begin
                    ibuf_valid_d = 1'b0;
                end
                // A lone buffer hit is served right here with no stall.
                if (!data_req && fetch_hit) begin
                    icache_dout_d = ibuf_data_q;
                end
`endif
                if (data_req) begin
                    state_d = D_REQ;
                end else if (icache_re && !fetch_hit) begin
                    state_d = I_REQ;
                end
            end

            D_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = d_addr_q;
                mem_req_rw    = d_is_store;
                mem_req_data  = d_din_q;
                mem_req_mask  = d_we_q;
                if (mem_req_ready) begin
                    state_d = D_WAIT;
                end
            end

            D_WAIT: begin
                if (mem_resp_valid) begin
                    if (d_is_load) begin
                        dcache_dout_d = mem_resp_data;
                    end
`ifdef MEM_RESP_IBUF_EN
                    if (i_hit_q) begin
                        icache_dout_d = ibuf_data_q;
                    end
`endif
                    state_d = i_pend_q ? I_REQ : IDLE;
                end
            end

            I_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = i_addr_q;
                if (mem_req_ready) begin
                    state_d = I_WAIT;
                end
            end

            I_WAIT: begin
                if (mem_resp_valid) begin
                    icache_dout_d = mem_resp_data;
`ifdef MEM_RESP_IBUF_EN
                    ibuf_valid_d = 1'b1;
                    ibuf_tag_d   = i_addr_q;
                    ibuf_data_d  = mem_resp_data;
`endif
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers. Reset is synchronous and active-low; the
    // backing memory shares it, so no stale response can follow a reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            i_addr_q      <= '0;
            d_addr_q      <= '0;
            d_din_q       <= '0;
            d_we_q        <= '0;
            d_re_q        <= 1'b0;
            i_pend_q      <= 1'b0;
            icache_dout_q <= '0;
            dcache_dout_q <= '0;
`ifdef MEM_RESP_IBUF_EN
            ibuf_valid_q  <= 1'b0;
            ibuf_tag_q    <= '0;
            ibuf_data_q   <= '0;
            i_hit_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            i_addr_q      <= i_addr_d;
            d_addr_q      <= d_addr_d;
            d_din_q       <= d_din_d;
            d_we_q        <= d_we_d;
            d_re_q        <= d_re_d;
            i_pend_q      <= i_pend_d;
            icache_dout_q <= icache_dout_d;
            dcache_dout_q <= dcache_dout_d;
`ifdef MEM_RESP_IBUF_EN
            ibuf_valid_q  <= ibuf_valid_d;
            ibuf_tag_q    <= ibuf_tag_d;
            ibuf_data_q   <= ibuf_data_d;
            i_hit_q       <= i_hit_d;
`endif
        end
    end

    assign icache_dout = icache_dout_q;
    assign dcache_dout = dcache_dout_q;
    assign stall       = (state_q != IDLE);

endmodule

// File: tb/tb_core_mem_responder.sv
//
// tb_core_mem_responder
//
// Directed bench for core_mem_responder. A table of transactions is driven
// through a simple backing-memory responder (ready as soon as a request is
// seen, response one cycle after acceptance); each row carries hand-computed
// request fields, stall length and returned words. Hand-written sequences
// cover backpressure, a same-cycle response, a stray response in IDLE and a
// reset in the middle of a fetch.
//
module tb_core_mem_responder;

    localparam int AW         = 30;
    localparam int MAX_CYCLES = 40;
    localparam int NUM_VECS   = 11;
`ifdef MEM_RESP_IBUF_EN
    localparam int HIT_STALL = 0;
    localparam int HIT_NREQ  = 0;
`else
    localparam int HIT_STALL = 2;
    localparam int HIT_NREQ  = 1;
`endif

    logic          clk;
    logic          reset;
    logic [31:0]   icache_addr;
    logic          icache_re;
    logic [31:0]   icache_dout;
    logic [31:0]   dcache_addr;
    logic          dcache_re;
    logic [3:0]    dcache_we;
    logic [31:0]   dcache_din;
    logic [31:0]   dcache_dout;
    logic          stall;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_rw;
    logic [31:0]   mem_req_data;
    logic [3:0]    mem_req_mask;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_data;

    core_mem_responder #(.MEM_ADDR_BITS(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_rw     (mem_req_rw),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   i_addr;
        logic          i_re;
        logic [31:0]   d_addr;
        logic          d_re;
        logic [3:0]    d_we;
        logic [31:0]   d_din;
        logic [31:0]   rdata0;
        logic [31:0]   rdata1;
        int            exp_stall;
        int            exp_nreq;
        logic [AW-1:0] exp_addr0;
        logic          exp_rw0;
        logic [3:0]    exp_mask0;
        logic [31:0]   exp_data0;
        logic [AW-1:0] exp_addr1;
        logic [31:0]   exp_idout;
        logic [31:0]   exp_ddout;
    } vec_t;

    vec_t          vecs[NUM_VECS];
    int            assertion_count = 0;
    int            failure_count   = 0;
    logic [AW-1:0] cap_addr[4];
    logic          cap_rw[4];
    logic [3:0]    cap_mask[4];
    logic [31:0]   cap_data[4];
    int            n_req;
    int            stall_count;

    // Single comparison point: every check steps the counters printed at the end.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertion_count++;
        if (actual !== expected) begin
            failure_count++;
            $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one row's request to the core for the current cycle.
    task automatic applyStimulus(input vec_t v);
        icache_addr = v.i_addr;
        icache_re   = v.i_re;
        dcache_addr = v.d_addr;
        dcache_re   = v.d_re;
        dcache_we   = v.d_we;
        dcache_din  = v.d_din;
    endtask

    // Run one row: drive the request, act as the backing memory until stall
    // drops (bounded), then compare what was issued and returned.
    task automatic runVector(input int idx);
        vec_t        v;
        logic        done;
        logic        resp_next;
        logic [31:0] resp_word;
        v = vecs[idx];
        for (int i = 0; i < 4; i++) begin
            cap_addr[i] = '0;
            cap_rw[i]   = 1'b0;
            cap_mask[i] = '0;
            cap_data[i] = '0;
        end
        applyStimulus(v);
        done        = 1'b0;
        resp_next   = 1'b0;
        resp_word   = '0;
        n_req       = 0;
        stall_count = 0;
        for (int c = 0; c < MAX_CYCLES && !done; c++) begin
            @(posedge clk);
            #1;
            icache_re      = 1'b0;
            dcache_re      = 1'b0;
            dcache_we      = 4'b0000;
            mem_resp_valid = resp_next;
            mem_resp_data  = resp_word;
            resp_next      = 1'b0;
            mem_req_ready  = 1'b0;
            if (!stall) begin
                done = 1'b1;
            end else begin
                stall_count++;
                if (mem_req_valid) begin
                    if (n_req < 4) begin
                        cap_addr[n_req] = mem_req_addr;
                        cap_rw[n_req]   = mem_req_rw;
                        cap_mask[n_req] = mem_req_mask;
                        cap_data[n_req] = mem_req_data;
                    end
                    resp_word     = (n_req == 0) ? v.rdata0 : v.rdata1;
                    n_req++;
                    mem_req_ready = 1'b1;
                    resp_next     = 1'b1;
                end
            end
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        checkOutput($sformatf("v%0d completed", idx), 32'(done), 32'd1);
        checkOutput($sformatf("v%0d stall cycles", idx), 32'(stall_count), 32'(v.exp_stall));
        checkOutput($sformatf("v%0d request count", idx), 32'(n_req), 32'(v.exp_nreq));
        checkOutput($sformatf("v%0d icache_dout", idx), icache_dout, v.exp_idout);
        checkOutput($sformatf("v%0d dcache_dout", idx), dcache_dout, v.exp_ddout);
        if (v.exp_nreq >= 1) begin
            checkOutput($sformatf("v%0d req0 addr", idx), 32'(cap_addr[0]), 32'(v.exp_addr0));
            checkOutput($sformatf("v%0d req0 rw", idx), 32'(cap_rw[0]), 32'(v.exp_rw0));
            checkOutput($sformatf("v%0d req0 mask", idx), 32'(cap_mask[0]), 32'(v.exp_mask0));
            if (v.exp_rw0) begin
                checkOutput($sformatf("v%0d req0 data", idx), cap_data[0], v.exp_data0);
            end
        end
        if (v.exp_nreq >= 2) begin
            checkOutput($sformatf("v%0d req1 addr", idx), 32'(cap_addr[1]), 32'(v.exp_addr1));
            checkOutput($sformatf("v%0d req1 rw", idx), 32'(cap_rw[1]), 32'd0);
            checkOutput($sformatf("v%0d req1 mask", idx), 32'(cap_mask[1]), 32'd0);
        end
    endtask

    // Main sequence: reset, table rows, then the multi-cycle corner cases.
    initial begin
        // Row fields: i_addr, i_re, d_addr, d_re, d_we, d_din, rdata0, rdata1,
        // stall, nreq, addr0, rw0, mask0, data0, addr1, icache_dout, dcache_dout.
        vecs[0]  = '{32'h0000_1004, 1'b1, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0013, 32'h0000_0000, 2, 1, 30'h401, 1'b0, 4'b0000, 32'h0000_0000, 30'h0, 32'h0000_0013, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0010, 1'b1, 32'h0000_0200, 1'b0, 4'b0100, 32'h00AB_0000, 32'hFFFF_FFFF, 32'h0000_0093, 4, 2, 30'h80, 1'b1, 4'b0100, 32'h00AB_0000, 30'h4, 32'h0000_0093, 32'h0000_0000};
        vecs[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0308, 1'b1, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 2, 1, 30'hC2, 1'b0, 4'b0000, 32'h0000_0000, 30'h0, 32'h0000_0093, 32'hCAFE_F00D};
        vecs[3]  = '{32'h0000_2000, 1'b1, 32'h0000_0404, 1'b1, 4'b0000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0513, 4, 2, 30'h101, 1'b0, 4'b0000, 32'h0000_0000, 30'h800, 32'h0000_0513, 32'h1234_5678};
        vecs[4]  = '{32'h0000_0000, 1'b0, 32'h0000_0500, 1'b1, 4'b1111, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1, 30'h140, 1'b1, 4'b1111, 32'hA5A5_5A5A, 30'h0, 32'h0000_0513, 32'h1234_5678};
        vecs[5]  = '{32'h0000_300E, 1'b1, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0073, 32'h0000_0000, 2, 1, 30'hC03, 1'b0, 4'b0000, 32'h0000_0000, 30'h0, 32'h0000_0073, 32'h1234_5678};
        vecs[6]  = '{32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 1'b0, 4'b0011, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1, 30'h3FFF_FFFF, 1'b1, 4'b0011, 32'h0000_BEEF, 30'h0, 32'h0000_0073, 32'h1234_5678};
        vecs[7]  = '{32'h0000_0040, 1'b1, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0A13, 32'h0000_0000, 2, 1, 30'h10, 1'b0, 4'b0000, 32'h0000_0000, 30'h0, 32'h0000_0A13, 32'h1234_5678};
        vecs[8]  = '{32'h0000_0040, 1'b1, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0A13, 32'h0000_0000, HIT_STALL, HIT_NREQ, 30'h10, 1'b0, 4'b0000, 32'h0000_0000, 30'h0, 32'h0000_0A13, 32'h1234_5678};
        vecs[9]  = '{32'h0000_0000, 1'b0, 32'h0000_0040, 1'b0, 4'b1111, 32'h0000_0C13, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1, 30'h10, 1'b1, 4'b1111, 32'h0000_0C13, 30'h0, 32'h0000_0A13, 32'h1234_5678};
        vecs[10] = '{32'h0000_0040, 1'b1, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0C13, 32'h0000_0000, 2, 1, 30'h10, 1'b0, 4'b0000, 32'h0000_0000, 30'h0, 32'h0000_0C13, 32'h1234_5678};

        reset          = 1'b0;
        icache_addr    = '0;
        icache_re      = 1'b0;
        dcache_addr    = '0;
        dcache_re      = 1'b0;
        dcache_we      = 4'b0000;
        dcache_din     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("reset mem_req_rw", 32'(mem_req_rw), 32'd0);
        checkOutput("reset mem_req_mask", 32'(mem_req_mask), 32'd0);
        checkOutput("reset mem_req_addr", 32'(mem_req_addr), 32'd0);
        checkOutput("reset mem_req_data", mem_req_data, 32'd0);
        checkOutput("reset icache_dout", icache_dout, 32'd0);
        checkOutput("reset dcache_dout", dcache_dout, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            runVector(i);
        end

        // Load with ready held low for 5 cycles; the request must stay put.
        // The acceptance cycle also carries a bogus response that must be ignored.
        dcache_addr = 32'h0000_0300;
        dcache_re   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            dcache_re = 1'b0;
            checkOutput($sformatf("bp c%0d stall", k), 32'(stall), 32'd1);
            checkOutput($sformatf("bp c%0d mem_req_valid", k), 32'(mem_req_valid), 32'd1);
            checkOutput($sformatf("bp c%0d mem_req_addr", k), 32'(mem_req_addr), 32'h0000_00C0);
        end
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111_1111;
        @(posedge clk);
        #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0BAD_F00D;
        checkOutput("bp wait stall", 32'(stall), 32'd1);
        checkOutput("bp wait mem_req_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        checkOutput("bp done stall", 32'(stall), 32'd0);
        checkOutput("bp dcache_dout", dcache_dout, 32'h0BAD_F00D);

        // Stray response while idle changes nothing.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        checkOutput("idle resp stall", 32'(stall), 32'd0);
        checkOutput("idle resp mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("idle resp icache_dout", icache_dout, 32'h0000_0C13);
        checkOutput("idle resp dcache_dout", dcache_dout, 32'h0BAD_F00D);

        // Reset asserted while waiting for a fetch response.
        icache_addr = 32'h0000_4000;
        icache_re   = 1'b1;
        @(posedge clk);
        #1;
        icache_re = 1'b0;
        checkOutput("rst seq req stall", 32'(stall), 32'd1);
        checkOutput("rst seq req addr", 32'(mem_req_addr), 32'h0000_1000);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        checkOutput("rst seq wait stall", 32'(stall), 32'd1);
        checkOutput("rst seq wait mem_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("rst seq stall", 32'(stall), 32'd0);
        checkOutput("rst seq mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst seq mem_req_addr", 32'(mem_req_addr), 32'd0);
        checkOutput("rst seq icache_dout", icache_dout, 32'd0);
        checkOutput("rst seq dcache_dout", dcache_dout, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end

endmodule
